// File: rtl/convpress_edram_writer.sv
// Packs variable-length compressed bricks into fixed Tn-entry eDRAM lines.
// A 2*Tn-1 entry pack buffer collects values. Each filled line is issued
// through a single registered write port that holds its value until it is
// acknowledged. At the end of a map, a partial line is flushed zero-padded.
module convpress_edram_writer #(
  parameter int N         = 16,
  parameter int Tn        = 16,
  parameter int ADDR_SIZE = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [ADDR_SIZE-1:0]   i_base_addr,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [Tn*N-1:0]        i_data,
  input  logic [$clog2(Tn):0]    i_count,
  input  logic                   i_last,
  output logic                   o_wr_en,
  input  logic                   i_wr_ready,
  output logic [ADDR_SIZE-1:0]   o_wr_addr,
  output logic [Tn*N-1:0]        o_wr_data,
  output logic [ADDR_SIZE:0]     o_lines,
  output logic                   o_done,
  output logic                   o_busy
);

  localparam int CW = $clog2(Tn) + 1;
  localparam int FW = $clog2(2*Tn) + 1;
  localparam int BE = 2*Tn - 1;
  localparam logic [CW-1:0]        TN_C  = CW'(Tn);
  localparam logic [FW-1:0]        TN_F  = FW'(Tn);
  localparam logic [ADDR_SIZE-1:0] A_ONE = ADDR_SIZE'(1);
  localparam logic [ADDR_SIZE:0]   L_ONE = (ADDR_SIZE+1)'(1);

  typedef enum logic [1:0] {IDLE, PACK, FLUSH, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [BE*N-1:0]        pbuf_q, pbuf_d;
  logic [FW-1:0]          fill_q, fill_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [ADDR_SIZE:0]     lines_q, lines_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
  logic [Tn*N-1:0]        wr_data_q, wr_data_d;
  logic                   done_q, done_d;

  logic [CW-1:0]          cnt;
  logic [FW-1:0]          sum;
  logic [Tn*N-1:0]        bdata;
  logic [BE*N-1:0]        abuf;
  logic                   out_free;
  logic                   accept;

  assign out_free = !wr_en_q || i_wr_ready;
  assign o_ready  = (state_q == PACK) && out_free;
  assign accept   = i_valid && o_ready;
  assign cnt      = (i_count > TN_C) ? TN_C : i_count;
  assign sum      = fill_q + FW'(cnt);

  // Lanes at or above count are forced to zero so stale data never enters the buffer.
  genvar k;
  generate
    for (k = 0; k < Tn; k++) begin : g_lane
      assign bdata[k*N +: N] = (CW'(k) < cnt) ? i_data[k*N +: N] : '0;
    end
  endgenerate

  // Entries at or above fill are always zero, so OR-ing the shifted brick appends it.
  assign abuf = pbuf_q | ({{((BE-Tn)*N){1'b0}}, bdata} << (fill_q * N));

  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_lines   = lines_q;
  assign o_done    = done_q;
  assign o_busy    = (state_q != IDLE);

  // Next-state: packing, line issue, flush, and end-of-map handshake.
  always_comb begin
    state_d   = state_q;
    pbuf_d    = pbuf_q;
    fill_d    = fill_q;
    addr_d    = addr_q;
    lines_d   = lines_q;
    wr_en_d   = wr_en_q && !i_wr_ready;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          addr_d  = i_base_addr;
          fill_d  = '0;
          pbuf_d  = '0;
          lines_d = '0;
          state_d = PACK;
        end
      end
      PACK: begin
        if (accept) begin
          if (sum >= TN_F) begin
            wr_en_d   = 1'b1;
            wr_data_d = abuf[Tn*N-1:0];
            wr_addr_d = addr_q;
            pbuf_d    = abuf >> (Tn*N);
            fill_d    = sum - TN_F;
            addr_d    = addr_q + A_ONE;
            lines_d   = lines_q + L_ONE;
          end else begin
            pbuf_d = abuf;
            fill_d = sum;
          end
          if (i_last) state_d = (fill_d != '0) ? FLUSH : DRAIN;
        end
      end
      FLUSH: begin
        if (out_free) begin
          // Unused upper entries are already zero, giving the padding for free.
          wr_en_d   = 1'b1;
          wr_data_d = pbuf_q[Tn*N-1:0];
          wr_addr_d = addr_q;
          pbuf_d    = '0;
          fill_d    = '0;
          addr_d    = addr_q + A_ONE;
          lines_d   = lines_q + L_ONE;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (out_free) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any buffered data and pending write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pbuf_q    <= '0;
      fill_q    <= '0;
      addr_q    <= '0;
      lines_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pbuf_q    <= pbuf_d;
      fill_q    <= fill_d;
      addr_q    <= addr_d;
      lines_q   <= lines_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_convpress_edram_writer.sv
// Bench for convpress_edram_writer: directed maps plus random ones, checked
// against a value-queue model of the packed output stream.
module tb_convpress_edram_writer;
  localparam int N  = 16;
  localparam int Tn = 16;
  localparam int AS = 10;
  localparam int LW = Tn*N;
  localparam int CW = $clog2(Tn) + 1;

  logic          clk;
  logic          rst;
  logic          i_start;
  logic [AS-1:0] i_base_addr;
  logic          i_valid;
  logic          o_ready;
  logic [LW-1:0] i_data;
  logic [CW-1:0] i_count;
  logic          i_last;
  logic          o_wr_en;
  logic          i_wr_ready;
  logic [AS-1:0] o_wr_addr;
  logic [LW-1:0] o_wr_data;
  logic [AS:0]   o_lines;
  logic          o_done;
  logic          o_busy;

  convpress_edram_writer #(.N(N), .Tn(Tn), .ADDR_SIZE(AS)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .i_count(i_count),
    .i_last(i_last), .o_wr_en(o_wr_en), .i_wr_ready(i_wr_ready),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_lines(o_lines),
    .o_done(o_done), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AS-1:0] a;
    logic [LW-1:0] d;
  } line_t;

  int            n_chk = 0;
  int            n_fail = 0;
  int            vq[$];
  line_t         exp_q[$];
  int            cnt_plan[$];
  logic [AS-1:0] m_addr;
  int            m_lines;
  bit            last_acc, exp_wr_next, done_next, stall_prev, done_seen;
  logic [AS-1:0] prev_a;
  logic [LW-1:0] prev_d;
  int            stall_left = 0;
  int            seqv;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop up to Tn values from the stream into one expected line, zero-padded.
  task automatic emit_line();
    line_t l;
    l.a = m_addr;
    l.d = '0;
    for (int k = 0; k < Tn; k++)
      if (vq.size() > 0) l.d[k*N +: N] = N'(vq.pop_front());
    exp_q.push_back(l);
    m_addr  = m_addr + 1'b1;
    m_lines = m_lines + 1;
  endtask

  task automatic set_ready(input int pct);
    if (stall_left > 0 && o_wr_en) begin
      i_wr_ready = 1'b0;
      stall_left--;
    end else begin
      i_wr_ready = ($urandom_range(0, 99) < pct);
    end
  endtask

  // One clock: inputs already driven; observe, check, update model, advance.
  task automatic cyc(output bit acc);
    bit ack;
    int c;
    #1;
    acc = i_valid && o_ready;
    ack = o_wr_en && i_wr_ready;
    if (exp_wr_next) chk("wr_latency", o_wr_en, 1'b1);
    exp_wr_next = 0;
    if (done_next) chk("done_after_ack", o_done, 1'b1);
    done_next = 0;
    if (stall_prev) begin
      chk("stall_en", o_wr_en, 1'b1);
      chk("stall_addr", o_wr_addr, prev_a);
      chk("stall_data", o_wr_data, prev_d);
    end
    if (o_wr_en && !i_wr_ready) chk("stall_ready", o_ready, 1'b0);
    if (ack) begin
      if (exp_q.size() == 0) chk("spurious_write", o_wr_en, 1'b0);
      else begin
        line_t l;
        l = exp_q.pop_front();
        chk("wr_addr", o_wr_addr, l.a);
        chk("wr_data", o_wr_data, l.d);
      end
      if (last_acc && exp_q.size() == 0) done_next = 1;
    end
    if (o_done) begin
      chk("done_early", (exp_q.size() == 0 && last_acc), 1'b1);
      done_seen = 1;
    end
    stall_prev = o_wr_en && !i_wr_ready;
    prev_a = o_wr_addr;
    prev_d = o_wr_data;
    if (acc) begin
      c = (i_count > Tn) ? Tn : int'(i_count);
      for (int k = 0; k < c; k++) vq.push_back(int'(i_data[k*N +: N]));
      if (vq.size() >= Tn) begin
        emit_line();
        exp_wr_next = 1;
      end
      if (i_last) begin
        last_acc = 1;
        if (vq.size() > 0) emit_line();
      end
    end
    @(negedge clk);
  endtask

  task automatic run_map(input logic [AS-1:0] base, input int nb, input bit seq,
                         input int pct, input int gap);
    bit acc;
    int tries, c, ng;
    vq.delete(); exp_q.delete();
    m_addr = base; m_lines = 0; last_acc = 0; done_seen = 0;
    exp_wr_next = 0; done_next = 0; stall_prev = 0; seqv = 1;
    i_start = 1'b1; i_base_addr = base; i_wr_ready = 1'b1;
    cyc(acc);
    i_start = 1'b0;
    chk("busy_after_start", o_busy, 1'b1);
    chk("lines_after_start", o_lines, 0);
    for (int b = 0; b < nb; b++) begin
      i_valid = 1'b1;
      i_last  = (b == nb - 1);
      i_count = (cnt_plan.size() > 0) ? CW'(cnt_plan.pop_front()) : CW'($urandom_range(0, 20));
      c = (i_count > Tn) ? Tn : int'(i_count);
      for (int k = 0; k < Tn; k++)
        i_data[k*N +: N] = (seq && k < c) ? N'(seqv + k) : N'($urandom);
      if (seq) seqv += c;
      tries = 0;
      do begin
        set_ready(pct);
        cyc(acc);
        tries++;
      end while (!acc && tries < 300);
      if (!acc) chk("accept_timeout", acc, 1'b1);
      if (pct == 100 && stall_left == 0) chk("throughput", tries, 1);
      i_valid = 1'b0;
      i_last  = 1'b0;
      if (b != nb - 1) begin
        ng = $urandom_range(0, gap);
        for (int g = 0; g < ng; g++) begin
          set_ready(pct);
          cyc(acc);
        end
      end
    end
    tries = 0;
    while (!done_seen && tries < 300) begin
      set_ready(pct > 0 ? pct : 50);
      cyc(acc);
      tries++;
    end
    chk("done_seen", done_seen, 1'b1);
    chk("done_pulse", o_done, 1'b0);
    chk("lines_left", exp_q.size(), 0);
    chk("o_lines", o_lines, m_lines);
    chk("busy_idle", o_busy, 1'b0);
    i_wr_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b0; i_start = 1'b0; i_base_addr = '0; i_valid = 1'b1;
    i_data = '0; i_count = '0; i_last = 1'b0; i_wr_ready = 1'b1;
    #12;
    chk("rst_wr_en", o_wr_en, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_lines", o_lines, 0);
    chk("rst_wr_addr", o_wr_addr, 0);
    chk("rst_wr_data", o_wr_data, 0);
    chk("rst_ready", o_ready, 1'b0);
    i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // V1: four 8-value bricks, values 1..32
    cnt_plan = '{8, 8, 8, 8};
    run_map(10'h100, 4, 1'b1, 100, 0);
    // V2: 10, 10, 3 with a zero-padded flush line
    cnt_plan = '{10, 10, 3};
    run_map(10'h000, 3, 1'b1, 100, 0);
    // V3: write port held off while a line is pending
    stall_left = 5;
    run_map(10'h200, 6, 1'b0, 90, 0);
    stall_left = 0;
    // V4: address wrap over 32 full bricks
    for (int i = 0; i < 32; i++) cnt_plan.push_back(16);
    run_map(10'h3FF, 32, 1'b0, 100, 0);
    // V5: empty last brick, then oversized counts
    cnt_plan = '{0};
    run_map(10'h010, 1, 1'b0, 100, 0);
    cnt_plan = '{20, 20, 20, 20};
    run_map(10'h020, 4, 1'b1, 100, 0);

    // V6: reset with a write pending
    i_start = 1'b1; i_base_addr = 10'h050;
    @(negedge clk);
    i_start = 1'b0; i_valid = 1'b1; i_count = CW'(16); i_last = 1'b0; i_wr_ready = 1'b0;
    for (int k = 0; k < Tn; k++) i_data[k*N +: N] = N'($urandom);
    @(negedge clk);
    i_valid = 1'b0;
    #1 chk("v6_pending", o_wr_en, 1'b1);
    rst = 1'b0;
    #1;
    chk("v6_rst_wr_en", o_wr_en, 1'b0);
    chk("v6_rst_busy", o_busy, 1'b0);
    chk("v6_rst_lines", o_lines, 0);
    @(negedge clk);
    rst = 1'b1; i_wr_ready = 1'b1;
    @(negedge clk);
    #1 chk("v6_no_wr", o_wr_en, 1'b0);
    @(negedge clk);
    run_map(10'h050, 6, 1'b1, 80, 2);

    // Random maps with random gaps, counts and write back-pressure
    for (int r = 0; r < 4; r++)
      run_map(AS'($urandom), $urandom_range(5, 20), 1'b0, 60, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
